archie_mem_loader: RTL and testbench

Parametrised Wishbone download loader. It sits between the hps_io ioctl download port and the SDRAM Wishbone arbiter mux in the emu top level. On a matching download it first fills a configurable SDRAM region with a fill pattern, then streams 8- or 16-bit ioctl words into that region with correct byte-lane selects. It flags overflow and aborted transfers and pulses `done` on a clean finish.

---
 rtl/archie_loader_pkg.sv | 36 +++
 rtl/archie_mem_loader.sv | 166 ++++++++++++++++
 tb/tb_archie_mem_loader.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/archie_loader_pkg.sv
// Shared types and byte-lane helpers for the archie download loader.
// The lane helpers turn one ioctl word into Wishbone byte enables and
// replicated write data, for both 8-bit and 16-bit download ports.
package archie_loader_pkg;

   // Loader sequencing: fill the region, then stream download words into it.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ERASE  = 2'd1,
      STREAM = 2'd2,
      WRITE  = 2'd3
   } loader_state_t;

   // Byte enables for one download word at byte offset addr within a 32-bit word.
   function automatic logic [3:0] lane_sel(input int width, input logic [1:0] addr);
      logic [3:0] sel;
      if (width == 8) begin
         sel = 4'b0001 << addr;
      end else begin
         sel = addr[1] ? 4'b1100 : 4'b0011;
      end
      return sel;
   endfunction

   // Write data with the download word replicated onto every lane it could hit.
   function automatic logic [31:0] lane_dat(input int width, input logic [15:0] d);
      logic [31:0] dat;
      if (width == 8) begin
         dat = {4{d[7:0]}};
      end else begin
         dat = {d, d};
      end
      return dat;
   endfunction

endpackage

// File: rtl/archie_mem_loader.sv
// Wishbone download loader between the hps_io ioctl port and the SDRAM
// arbiter. A matching download first fills the region with FILL, then each
// ioctl word becomes one Wishbone write with the right byte lanes.
//
// Handshakes: a Wishbone cycle is outstanding while wb_stb is high and
// completes on the clock edge that samples wb_ack high; wb_ack is ignored
// while wb_stb is low. On the ioctl side a word is accepted on any cycle
// with ioctl_wr high while ioctl_wait is low; ioctl_wait stays high while
// the loader cannot take another word (erase, write in flight).
module archie_mem_loader
   import archie_loader_pkg::*;
#(
   parameter int               DL_WIDTH     = 16,
   parameter int               ADDR_W       = 24,
   parameter logic [ADDR_W-1:0] BASE_WORD   = ADDR_W'(32'h0010_0000),
   parameter int               REGION_WORDS = 2**20,
   parameter logic [31:0]      FILL         = 32'h0,
   parameter logic [7:0]       INDEX        = 8'd1
) (
   input  logic                clk_sys,
   input  logic                reset_n,
   input  logic                ioctl_download,
   input  logic [7:0]          ioctl_index,
   input  logic                ioctl_wr,
   input  logic [24:0]         ioctl_addr,
   input  logic [DL_WIDTH-1:0] ioctl_dout,
   output logic                ioctl_wait,
   output logic                active,
   output logic                wb_stb,
   output logic                wb_cyc,
   output logic                wb_we,
   output logic [3:0]          wb_sel,
   output logic [ADDR_W-1:0]   wb_adr,
   output logic [31:0]         wb_dat_o,
   input  logic                wb_ack,
   output logic                done,
   output logic                err,
   output loader_state_t       dbg_state
);

   localparam int PTR_W = $clog2(REGION_WORDS);

   loader_state_t    state;
   logic             sel_dl;
   logic             sel_dl_q;
   logic             sel_dl_rise;
   logic             abort_pend;
   logic [PTR_W-1:0] erase_ptr;
   logic [PTR_W-1:0] next_ptr;
   logic [22:0]      woff;
   logic             woff_oob;

   assign sel_dl      = ioctl_download && (ioctl_index == INDEX);
   assign sel_dl_rise = sel_dl && !sel_dl_q;
   assign next_ptr    = erase_ptr + PTR_W'(1);
   assign woff        = ioctl_addr[24:2];
   assign woff_oob    = {9'd0, woff} >= 32'(REGION_WORDS);
   assign dbg_state   = state;

   // Loader sequencer: all bus and handshake outputs are registered here.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         sel_dl_q   <= 1'b0;
         abort_pend <= 1'b0;
         erase_ptr  <= '0;
         ioctl_wait <= 1'b0;
         active     <= 1'b0;
         wb_stb     <= 1'b0;
         wb_cyc     <= 1'b0;
         wb_we      <= 1'b0;
         wb_sel     <= 4'h0;
         wb_adr     <= '0;
         wb_dat_o   <= 32'h0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         sel_dl_q <= sel_dl;
         done     <= 1'b0;
         case (state)
            IDLE: begin
               if (sel_dl_rise) begin
                  state      <= ERASE;
                  erase_ptr  <= '0;
                  abort_pend <= 1'b0;
                  err        <= 1'b0;
                  active     <= 1'b1;
                  ioctl_wait <= 1'b1;
                  wb_stb     <= 1'b1;
                  wb_cyc     <= 1'b1;
                  wb_we      <= 1'b1;
                  wb_sel     <= 4'hF;
                  wb_adr     <= BASE_WORD;
                  wb_dat_o   <= FILL;
               end
            end
            ERASE: begin
               // A dropped download is remembered so the cycle in flight can finish first.
               if (!sel_dl) begin
                  abort_pend <= 1'b1;
               end
               if (ioctl_wr) begin
                  err <= 1'b1;
               end
               if (wb_ack) begin
                  if (abort_pend || !sel_dl) begin
                     state      <= IDLE;
                     err        <= 1'b1;
                     active     <= 1'b0;
                     ioctl_wait <= 1'b0;
                     wb_stb     <= 1'b0;
                     wb_cyc     <= 1'b0;
                     wb_we      <= 1'b0;
                  end else if (erase_ptr == PTR_W'(REGION_WORDS - 1)) begin
                     state      <= STREAM;
                     ioctl_wait <= 1'b0;
                     wb_stb     <= 1'b0;
                     wb_cyc     <= 1'b0;
                     wb_we      <= 1'b0;
                  end else begin
                     // Strobe stays up so erase cycles run back to back.
                     erase_ptr <= next_ptr;
                     wb_adr    <= BASE_WORD + ADDR_W'(next_ptr);
                  end
               end
            end
            STREAM: begin
               if (ioctl_wr) begin
                  if (woff_oob) begin
                     err <= 1'b1;
                  end else begin
                     state      <= WRITE;
                     ioctl_wait <= 1'b1;
                     wb_stb     <= 1'b1;
                     wb_cyc     <= 1'b1;
                     wb_we      <= 1'b1;
                     wb_sel     <= lane_sel(DL_WIDTH, ioctl_addr[1:0]);
                     wb_adr     <= BASE_WORD + ADDR_W'(woff);
                     wb_dat_o   <= lane_dat(DL_WIDTH, 16'(ioctl_dout));
                  end
               end else if (!sel_dl) begin
                  state  <= IDLE;
                  active <= 1'b0;
                  done   <= !err;
               end
            end
            WRITE: begin
               if (ioctl_wr) begin
                  err <= 1'b1;
               end
               if (wb_ack) begin
                  state      <= STREAM;
                  ioctl_wait <= 1'b0;
                  wb_stb     <= 1'b0;
                  wb_cyc     <= 1'b0;
                  wb_we      <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_archie_mem_loader.sv
// Bench for archie_mem_loader: a 16-bit and an 8-bit instance, each with a
// small 4-word region, a Wishbone slave with programmable ack delay, and a
// monitor that pops expected bus writes from a per-instance queue.
module tb_archie_mem_loader;
   import archie_loader_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk_sys = 1'b0;
   logic reset_n;
   always #5 clk_sys = ~clk_sys;

   // ---------------- instance A (16-bit) ----------------
   logic          a_dl, a_wr, a_wait, a_active, a_stb, a_cyc, a_we, a_ack, a_done, a_err;
   logic [7:0]    a_idx;
   logic [24:0]   a_addr;
   logic [15:0]   a_dout;
   logic [3:0]    a_sel;
   logic [23:0]   a_adr;
   logic [31:0]   a_dat;
   loader_state_t a_state;

   // ---------------- instance B (8-bit) ----------------
   logic          b_dl, b_wr, b_wait, b_active, b_stb, b_cyc, b_we, b_ack, b_done, b_err;
   logic [7:0]    b_idx;
   logic [24:0]   b_addr;
   logic [7:0]    b_dout;
   logic [3:0]    b_sel;
   logic [23:0]   b_adr;
   logic [31:0]   b_dat;
   loader_state_t b_state;

   // ---------------- scoreboard state ----------------
   logic [59:0] exp_a[$];          // {adr, sel, dat}
   logic [59:0] exp_b[$];
   logic [31:0] mem_b[int];
   int a_dly = 0, b_dly = 0;
   int a_cnt, b_cnt;
   int a_done_cnt = 0, b_done_cnt = 0, a_stb_seen = 0;
   int n_checks = 0, n_err = 0;

   archie_mem_loader #(
      .DL_WIDTH(16), .ADDR_W(24), .BASE_WORD(24'h100000),
      .REGION_WORDS(4), .FILL(32'hDEADBEEF), .INDEX(8'd1)
   ) dut_a (
      .clk_sys(clk_sys), .reset_n(reset_n),
      .ioctl_download(a_dl), .ioctl_index(a_idx), .ioctl_wr(a_wr),
      .ioctl_addr(a_addr), .ioctl_dout(a_dout), .ioctl_wait(a_wait),
      .active(a_active), .wb_stb(a_stb), .wb_cyc(a_cyc), .wb_we(a_we),
      .wb_sel(a_sel), .wb_adr(a_adr), .wb_dat_o(a_dat), .wb_ack(a_ack),
      .done(a_done), .err(a_err), .dbg_state(a_state)
   );

   archie_mem_loader #(
      .DL_WIDTH(8), .ADDR_W(24), .BASE_WORD(24'h100000),
      .REGION_WORDS(4), .FILL(32'hDEADBEEF), .INDEX(8'd1)
   ) dut_b (
      .clk_sys(clk_sys), .reset_n(reset_n),
      .ioctl_download(b_dl), .ioctl_index(b_idx), .ioctl_wr(b_wr),
      .ioctl_addr(b_addr), .ioctl_dout(b_dout), .ioctl_wait(b_wait),
      .active(b_active), .wb_stb(b_stb), .wb_cyc(b_cyc), .wb_we(b_we),
      .wb_sel(b_sel), .wb_adr(b_adr), .wb_dat_o(b_dat), .wb_ack(b_ack),
      .done(b_done), .err(b_err), .dbg_state(b_state)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- Wishbone slaves: ack a_dly+1 cycles after strobe ----------------
   always @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         a_ack <= 1'b0; a_cnt <= 0;
      end else if (a_stb && !a_ack) begin
         if (a_cnt >= a_dly) begin a_ack <= 1'b1; a_cnt <= 0; end
         else a_cnt <= a_cnt + 1;
      end else begin
         a_ack <= 1'b0; a_cnt <= 0;
      end
   end

   always @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         b_ack <= 1'b0; b_cnt <= 0;
      end else if (b_stb && !b_ack) begin
         if (b_cnt >= b_dly) begin b_ack <= 1'b1; b_cnt <= 0; end
         else b_cnt <= b_cnt + 1;
      end else begin
         b_ack <= 1'b0; b_cnt <= 0;
      end
   end

   // ---------------- monitors ----------------
   always @(negedge clk_sys) begin
      logic [59:0] e;
      if (reset_n) begin
         if (a_done) a_done_cnt++;
         if (a_stb) a_stb_seen++;
         if (a_stb && a_ack) begin
            if (exp_a.size() == 0) begin
               n_checks++; n_err++;
               $display("FAIL bus_a unexpected: adr %0h sel %0h dat %0h", a_adr, a_sel, a_dat);
            end else begin
               e = exp_a.pop_front();
               check("bus_a", {2'b00, a_we, a_cyc, a_adr, a_sel, a_dat}, {4'b0011, e});
            end
         end
      end
   end

   always @(negedge clk_sys) begin
      logic [59:0] e;
      logic [31:0] w;
      if (reset_n) begin
         if (b_done) b_done_cnt++;
         if (b_stb && b_ack) begin
            w = mem_b.exists(int'(b_adr)) ? mem_b[int'(b_adr)] : 32'h0;
            for (int i = 0; i < 4; i++) if (b_sel[i]) w[8*i +: 8] = b_dat[8*i +: 8];
            mem_b[int'(b_adr)] = w;
            if (exp_b.size() == 0) begin
               n_checks++; n_err++;
               $display("FAIL bus_b unexpected: adr %0h sel %0h dat %0h", b_adr, b_sel, b_dat);
            end else begin
               e = exp_b.pop_front();
               check("bus_b", {2'b00, b_we, b_cyc, b_adr, b_sel, b_dat}, {4'b0011, e});
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_ready(input bit use_b, input string name);
      int i = 0;
      while ((use_b ? b_wait : a_wait) && i < 300) begin @(negedge clk_sys); i++; end
      check({name, "_wait_low"}, use_b ? b_wait : a_wait, 1'b0);
   endtask

   task automatic wait_idle(input bit use_b, input string name);
      int i = 0;
      while ((use_b ? b_active : a_active) && i < 300) begin @(negedge clk_sys); i++; end
      check({name, "_inactive"}, use_b ? b_active : a_active, 1'b0);
   endtask

   task automatic start_dl(input bit use_b, input int n_erase);
      for (int i = 0; i < n_erase; i++) begin
         if (use_b) exp_b.push_back({24'h100000 + 24'(i), 4'hF, 32'hDEADBEEF});
         else       exp_a.push_back({24'h100000 + 24'(i), 4'hF, 32'hDEADBEEF});
      end
      if (use_b) b_dl = 1'b1; else a_dl = 1'b1;
      @(negedge clk_sys);
   endtask

   task automatic do_write(input bit use_b, input logic [24:0] addr, input logic [15:0] d,
                           input logic [23:0] e_adr, input logic [3:0] e_sel,
                           input logic [31:0] e_dat, input bit bus, input string name);
      wait_ready(use_b, name);
      if (bus) begin
         if (use_b) exp_b.push_back({e_adr, e_sel, e_dat});
         else       exp_a.push_back({e_adr, e_sel, e_dat});
      end
      if (use_b) begin b_addr = addr; b_dout = d[7:0]; b_wr = 1'b1; end
      else       begin a_addr = addr; a_dout = d;      a_wr = 1'b1; end
      @(negedge clk_sys);
      a_wr = 1'b0; b_wr = 1'b0;
      check({name, "_latency"}, use_b ? b_stb : a_stb, bus);
      @(negedge clk_sys);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int base;
      a_dl = 0; a_wr = 0; a_idx = 8'd1; a_addr = '0; a_dout = '0;
      b_dl = 0; b_wr = 0; b_idx = 8'd1; b_addr = '0; b_dout = '0;
      reset_n = 1'b0;
      repeat (3) @(negedge clk_sys);
      check("reset_ctl", {a_wait, a_active, a_stb, a_cyc, a_we, a_done, a_err, a_sel, a_state}, '0);
      check("reset_bus", {a_adr, a_dat}, '0);
      reset_n = 1'b1;
      @(negedge clk_sys);

      // Erase of a 4-word region followed by two 16-bit writes.
      start_dl(0, 4);
      check("erase_start", {a_active, a_wait, a_stb, a_sel}, {3'b111, 4'hF});
      wait_ready(0, "erase_a");
      check("erase_all_seen", exp_a.size(), 0);
      check("erase_to_stream", a_state, STREAM);
      do_write(0, 25'd0, 16'h1234, 24'h100000, 4'b0011, 32'h12341234, 1, "w16_lo");
      do_write(0, 25'd2, 16'hABCD, 24'h100000, 4'b1100, 32'hABCDABCD, 1, "w16_hi");
      wait_ready(0, "w16_end");
      a_dl = 1'b0;
      wait_idle(0, "w16");
      repeat (2) @(negedge clk_sys);
      check("w16_done_once", a_done_cnt, 1);
      check("w16_err", a_err, 1'b0);

      // 8-bit lanes merging into one word.
      start_dl(1, 4);
      wait_ready(1, "erase_b");
      do_write(1, 25'd0, 16'h11, 24'h100000, 4'b0001, 32'h11111111, 1, "w8_0");
      do_write(1, 25'd1, 16'h22, 24'h100000, 4'b0010, 32'h22222222, 1, "w8_1");
      do_write(1, 25'd2, 16'h33, 24'h100000, 4'b0100, 32'h33333333, 1, "w8_2");
      do_write(1, 25'd3, 16'h44, 24'h100000, 4'b1000, 32'h44444444, 1, "w8_3");
      wait_ready(1, "w8_end");
      b_dl = 1'b0;
      wait_idle(1, "w8");
      repeat (2) @(negedge clk_sys);
      check("w8_merged", mem_b[32'h100000], 32'h44332211);
      check("w8_done_once", b_done_cnt, 1);

      // Out-of-range write: dropped, error, no done.
      base = a_done_cnt;
      start_dl(0, 4);
      wait_ready(0, "erase_oob");
      do_write(0, 25'd16, 16'h5555, 24'h0, 4'h0, 32'h0, 0, "oob");
      check("oob_err", a_err, 1'b1);
      a_dl = 1'b0;
      wait_idle(0, "oob");
      repeat (2) @(negedge clk_sys);
      check("oob_no_done", a_done_cnt, base);

      // Download drops during erase with a slow slave.
      a_dly = 5;
      base = a_done_cnt;
      start_dl(0, 1);
      check("err_cleared", a_err, 1'b0);
      repeat (2) @(negedge clk_sys);
      a_dl = 1'b0;
      @(negedge clk_sys);
      check("abort_stb_held", a_stb, 1'b1);
      wait_idle(0, "abort");
      check("abort_err", {a_err, a_stb}, 2'b10);
      repeat (3) @(negedge clk_sys);
      check("abort_no_done", a_done_cnt, base);
      check("abort_one_cycle", exp_a.size(), 0);

      // Download for another index leaves the loader alone.
      base = a_stb_seen;
      a_idx = 8'd2; a_dl = 1'b1;
      repeat (10) @(negedge clk_sys);
      check("other_index", {a_active, 8'(a_stb_seen - base)}, 9'd0);
      a_dl = 1'b0;
      @(negedge clk_sys);
      a_idx = 8'd1;
      @(negedge clk_sys);

      // Asynchronous reset while a write is in flight.
      a_dly = 4;
      start_dl(0, 4);
      wait_ready(0, "erase_rst");
      a_addr = 25'd4; a_dout = 16'h7777; a_wr = 1'b1;
      @(negedge clk_sys);
      a_wr = 1'b0;
      check("in_write", a_state, WRITE);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_ctl", {a_wait, a_active, a_stb, a_cyc, a_we, a_done, a_err, a_sel, a_state}, '0);
      check("async_rst_bus", {a_adr, a_dat}, '0);
      a_dl = 1'b0;
      @(negedge clk_sys);
      reset_n = 1'b1;
      repeat (2) @(negedge clk_sys);

      check("queues_empty", exp_a.size() + exp_b.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
